clk_div_ctrl: RTL

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl_pkg.sv | 27 ++
 rtl/clk_div_ctrl_rr_arb2.sv | 46 ++++
 rtl/clk_div_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and defaults for the clock-divider reconfiguration controller.
// Used by clk_div_ctrl and rr_arb2.
package clk_div_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_ENABLE = 3'd4
  } state_e;

  localparam int DEF_DRAIN_CYC     = 4;
  localparam int DEF_SETTLE_CYC    = 2;
  localparam int DEF_DEFAULT_RATIO = 16;
  localparam int CNT_W             = 8;

  // A phase of N cycles is counted N-1 down to 0.
  function automatic logic [CNT_W-1:0] cyc_to_cnt(input int cyc);
    if (cyc > 1) begin
      return CNT_W'(cyc - 1);
    end else begin
      return {CNT_W{1'b0}};
    end
  endfunction

endpackage

// File: rtl/clk_div_ctrl_rr_arb2.sv
// Two-input round-robin arbiter.
// The grant is combinational; the pointer moves only when the grant is accepted.
module rr_arb2 (
  input  logic       i_ref_clk,
  input  logic       i_rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic prio1_r;

  // Grant selection: the pointer names the requester with priority.
  always_comb begin
    gnt = 2'b00;
    if (prio1_r) begin
      if (req[1]) begin
        gnt = 2'b10;
      end else if (req[0]) begin
        gnt = 2'b01;
      end else begin
        gnt = 2'b00;
      end
    end else begin
      if (req[0]) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end else begin
        gnt = 2'b00;
      end
    end
  end

  // Pointer update: the requester just served loses priority.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prio1_r <= 1'b0;
    end else if (accept && (gnt != 2'b00)) begin
      prio1_r <= gnt[0];
    end else begin
      prio1_r <= prio1_r;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Sequences ratio changes of a clock divider: drain, load, settle, re-enable.
// Optional range check of captured ratios with CLK_DIV_CTRL_RANGE_CHECK_EN.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int WIDTH         = 6,
  parameter int DEFAULT_RATIO = DEF_DEFAULT_RATIO,
  parameter int DRAIN_CYC     = DEF_DRAIN_CYC,
  parameter int SETTLE_CYC    = DEF_SETTLE_CYC
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic [WIDTH-1:0] i_ratio0,
  input  logic [WIDTH-1:0] i_ratio1,
  output logic             o_ack0,
  output logic             o_ack1,
  output logic             o_clk_en,
  output logic [WIDTH-1:0] o_div_ratio,
  output logic             o_busy
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
  ,
  output logic             o_err
`endif
);

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             sel_r, sel_s;
  logic [WIDTH-1:0] ratio_r, ratio_s;
  logic [WIDTH-1:0] cap_ratio_s;
  logic [WIDTH-1:0] div_s;
  logic [1:0]       gnt_s;
  logic             accept_s;
  logic             reject_s;
  logic             ack_any_s;
  logic             ack0_s, ack1_s, clk_en_s, busy_s;

  rr_arb2 u_arb (
    .i_ref_clk (i_ref_clk),
    .i_rst_n   (i_rst_n),
    .req       ({i_req1, i_req0}),
    .accept    (accept_s),
    .gnt       (gnt_s)
  );

  // Next-state and next-output logic; outputs are derived from the next state.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    sel_s       = sel_r;
    ratio_s     = ratio_r;
    div_s       = o_div_ratio;
    accept_s    = 1'b0;
    reject_s    = 1'b0;
    cap_ratio_s = gnt_s[1] ? i_ratio1 : i_ratio0;

    case (state_r)
      ST_IDLE: begin
        if (gnt_s != 2'b00) begin
          accept_s = 1'b1;
          sel_s    = gnt_s[1];
          ratio_s  = cap_ratio_s;
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
          reject_s = (cap_ratio_s < WIDTH'(2));
`else
          reject_s = 1'b0;
`endif
          if (reject_s) begin
            state_s = ST_IDLE;
          end else if (cap_ratio_s == o_div_ratio) begin
            // Same ratio: nothing to reprogram, acknowledge straight away.
            state_s = ST_ENABLE;
          end else begin
            state_s = ST_DRAIN;
            cnt_s   = cyc_to_cnt(DRAIN_CYC);
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_LOAD;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_LOAD: begin
        div_s   = ratio_r;
        state_s = ST_SETTLE;
        cnt_s   = cyc_to_cnt(SETTLE_CYC);
      end
      ST_SETTLE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_ENABLE;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_ENABLE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase

    clk_en_s  = (state_s == ST_IDLE) || (state_s == ST_ENABLE);
    busy_s    = (state_s != ST_IDLE);
    ack_any_s = ((state_s == ST_ENABLE) && (state_r != ST_ENABLE)) || reject_s;
    ack0_s    = ack_any_s && !sel_s;
    ack1_s    = ack_any_s && sel_s;
  end

  // State, capture and counter registers.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      sel_r   <= 1'b0;
      ratio_r <= WIDTH'(DEFAULT_RATIO);
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      sel_r   <= sel_s;
      ratio_r <= ratio_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ack0      <= 1'b0;
      o_ack1      <= 1'b0;
      o_clk_en    <= 1'b1;
      o_div_ratio <= WIDTH'(DEFAULT_RATIO);
      o_busy      <= 1'b0;
    end else begin
      o_ack0      <= ack0_s;
      o_ack1      <= ack1_s;
      o_clk_en    <= clk_en_s;
      o_div_ratio <= div_s;
      o_busy      <= busy_s;
    end
  end

`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
  // Reject pulse, coincident with the ack of the rejected request.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err <= 1'b0;
    end else begin
      o_err <= reject_s;
    end
  end
`endif

endmodule
